// File: rtl/tqv_periph_bus_master.sv
// Single-outstanding bus initiator for the TinyQV peripheral bus.
// Turns command-channel requests into bus strobes and returns data or an error.
module tqv_periph_bus_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [10:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [10:0] addr_out,
    output logic [31:0] data_out,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_in,
    input  logic        data_ready,
    output logic        data_read_complete
);

    localparam logic [1:0]  SIZE_BYTE    = 2'b00;
    localparam logic [1:0]  SIZE_HALF    = 2'b01;
    localparam logic [1:0]  BUS_IDLE     = 2'b11;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_COMPLETE,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] count_q, count_d;
    logic        cmdReady_q, cmdReady_d;
    logic        rspValid_q, rspValid_d;
    logic [31:0] rspRdata_q, rspRdata_d;
    logic        rspError_q, rspError_d;
    logic [10:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  writeN_q, writeN_d;
    logic [1:0]  readN_q, readN_d;
    logic        complete_q, complete_d;
    logic [31:0] readMasked;

    always_comb begin
        case (size_q)
            SIZE_BYTE: readMasked = {24'b0, data_in[7:0]};
            SIZE_HALF: readMasked = {16'b0, data_in[15:0]};
            default:   readMasked = data_in;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        count_d    = count_q;
        cmdReady_d = cmdReady_q;
        rspValid_d = rspValid_q;
        rspRdata_d = rspRdata_q;
        rspError_d = rspError_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        writeN_d   = writeN_q;
        readN_d    = readN_q;
        complete_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmdReady_d = 1'b1;
                count_d    = '0;
                if (cmd_valid && cmdReady_q) begin
                    cmdReady_d = 1'b0;
                    if (cmd_size == BUS_IDLE) begin
                        // Illegal size never touches the bus
                        rspValid_d = 1'b1;
                        rspError_d = 1'b1;
                        rspRdata_d = '0;
                        state_d    = S_RESP;
                    end else begin
                        size_d = cmd_size;
                        addr_d = cmd_addr;
                        if (cmd_write) begin
                            wdata_d  = cmd_wdata;
                            writeN_d = cmd_size;
                            state_d  = S_WRITE;
                        end else begin
                            readN_d = cmd_size;
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (data_ready || count_q == TIMEOUT_LAST) begin
                    writeN_d   = BUS_IDLE;
                    rspValid_d = 1'b1;
                    rspError_d = !data_ready;
                    rspRdata_d = '0;
                    state_d    = S_RESP;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            S_READ: begin
                if (data_ready) begin
                    readN_d    = BUS_IDLE;
                    complete_d = 1'b1;
                    rspRdata_d = readMasked;
                    state_d    = S_COMPLETE;
                end else if (count_q == TIMEOUT_LAST) begin
                    readN_d    = BUS_IDLE;
                    rspValid_d = 1'b1;
                    rspError_d = 1'b1;
                    rspRdata_d = '0;
                    state_d    = S_RESP;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            S_COMPLETE: begin
                rspValid_d = 1'b1;
                rspError_d = 1'b0;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rspValid_d = 1'b0;
                    rspRdata_d = '0;
                    rspError_d = 1'b0;
                    cmdReady_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            size_q     <= '0;
            count_q    <= '0;
            cmdReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspError_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            writeN_q   <= BUS_IDLE;
            readN_q    <= BUS_IDLE;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            count_q    <= count_d;
            cmdReady_q <= cmdReady_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspError_q <= rspError_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            writeN_q   <= writeN_d;
            readN_q    <= readN_d;
            complete_q <= complete_d;
        end
    end

    assign cmd_ready          = cmdReady_q;
    assign rsp_valid          = rspValid_q;
    assign rsp_rdata          = rspRdata_q;
    assign rsp_error          = rspError_q;
    assign addr_out           = addr_q;
    assign data_out           = wdata_q;
    assign data_write_n       = writeN_q;
    assign data_read_n        = readN_q;
    assign data_read_complete = complete_q;

endmodule

// File: tb/tb_tqv_periph_bus_master.sv
// Randomized bench for tqv_periph_bus_master; expected responses and timing
// come from a transaction-level model of strobe length, latency and data.
module tb_tqv_periph_bus_master;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [10:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [10:0] addr_out;
    logic [31:0] data_out;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_in;
    logic        data_ready;
    logic        data_read_complete;

    int checks   = 0;
    int failures = 0;

    tqv_periph_bus_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .addr_out(addr_out), .data_out(data_out),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_in(data_in), .data_ready(data_ready),
        .data_read_complete(data_read_complete)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs observed 1ns after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_size   = 2'b00;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        rsp_ready  = 1'b0;
        data_in    = '0;
        data_ready = 1'b0;
        rst_n      = 1'b0;
        step();
        step();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        checks++; if (rsp_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_error got %b want 0", rsp_error); end
        checks++; if (addr_out !== 11'h0) begin failures++; $display("[TB] FAIL reset_addr_out got %h want 0", addr_out); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_data_out got %h want 0", data_out); end
        checks++; if (data_write_n !== 2'b11) begin failures++; $display("[TB] FAIL reset_write_n got %b want 11", data_write_n); end
        checks++; if (data_read_n !== 2'b11) begin failures++; $display("[TB] FAIL reset_read_n got %b want 11", data_read_n); end
        checks++; if (data_read_complete !== 1'b0) begin failures++; $display("[TB] FAIL reset_complete got %b want 0", data_read_complete); end
        rst_n = 1'b1;
        step();
    endtask

    // One full transaction: d is the 0-based request cycle in which the
    // peripheral raises data_ready (d >= T means never); hold delays rsp_ready
    task automatic run_txn(input string name, input logic wr, input logic [1:0] sz,
                           input logic [10:0] addr, input logic [31:0] wdata,
                           input int d, input logic [31:0] rdin, input int hold);
        bit          illegal, tmo;
        int          expStrobe, expRspAt, expComp;
        logic [31:0] expR;
        logic        expE;
        int          strobeSeen, firstStrobe, compCount, compAt, rspAt;
        logic [1:0]  expW, expRd;

        illegal   = (sz == 2'b11);
        tmo       = !illegal && (d >= T);
        expStrobe = illegal ? 0 : (tmo ? T : d + 1);
        expE      = illegal || tmo;
        expR      = 32'h0;
        if (!wr && !expE) begin
            if (sz == 2'b00)      expR = rdin & 32'h0000_00FF;
            else if (sz == 2'b01) expR = rdin & 32'h0000_FFFF;
            else                  expR = rdin;
        end
        expComp  = (!wr && !expE) ? 1 : 0;
        expRspAt = illegal ? 1 : ((expComp == 1) ? expStrobe + 2 : expStrobe + 1);
        expW     = wr ? sz : 2'b11;
        expRd    = wr ? 2'b11 : sz;

        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL %s cmd_ready_offer got %b want 1", name, cmd_ready); end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_size  = sz;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_size  = 2'($urandom_range(0, 3));
        cmd_addr  = 11'($urandom);
        cmd_wdata = $urandom;

        strobeSeen  = 0;
        firstStrobe = -1;
        compCount   = 0;
        compAt      = -1;
        rspAt       = -1;
        for (int j = 1; j <= T + 20 && rspAt < 0; j++) begin
            if (data_write_n !== 2'b11 || data_read_n !== 2'b11) begin
                if (firstStrobe < 0) firstStrobe = j;
                checks++;
                if (data_write_n !== expW || data_read_n !== expRd) begin
                    failures++;
                    $display("[TB] FAIL %s strobe_code got w=%b r=%b want w=%b r=%b", name, data_write_n, data_read_n, expW, expRd);
                end
                checks++; if (addr_out !== addr) begin failures++; $display("[TB] FAIL %s addr_out got %h want %h", name, addr_out, addr); end
                if (wr) begin
                    checks++; if (data_out !== wdata) begin failures++; $display("[TB] FAIL %s data_out got %h want %h", name, data_out, wdata); end
                end
                data_ready = (strobeSeen == d);
                data_in    = data_ready ? rdin : $urandom;
                strobeSeen++;
            end else begin
                data_ready = 1'($urandom_range(0, 1));
                data_in    = $urandom;
            end
            if (data_read_complete === 1'b1) begin
                compCount++;
                compAt = j;
            end
            if (rsp_valid === 1'b1) begin
                rspAt = j;
            end else begin
                checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL %s cmd_ready_busy got %b want 0", name, cmd_ready); end
                step();
            end
        end
        data_ready = 1'b0;

        checks++;
        if (rspAt < 0) begin
            failures++;
            $display("[TB] FAIL %s rsp_never_valid got none want cycle %0d", name, expRspAt);
            applyReset(2);
            return;
        end
        if (rspAt != expRspAt) begin failures++; $display("[TB] FAIL %s rsp_latency got %0d want %0d", name, rspAt, expRspAt); end
        checks++; if (strobeSeen != expStrobe) begin failures++; $display("[TB] FAIL %s strobe_len got %0d want %0d", name, strobeSeen, expStrobe); end
        if (expStrobe > 0) begin
            checks++; if (firstStrobe != 1) begin failures++; $display("[TB] FAIL %s strobe_start got %0d want 1", name, firstStrobe); end
        end
        checks++; if (compCount != expComp) begin failures++; $display("[TB] FAIL %s complete_count got %0d want %0d", name, compCount, expComp); end
        if (expComp == 1) begin
            checks++; if (compAt != expStrobe + 1) begin failures++; $display("[TB] FAIL %s complete_cycle got %0d want %0d", name, compAt, expStrobe + 1); end
        end

        for (int h = 0; h <= hold; h++) begin
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL %s rsp_valid_hold got %b want 1", name, rsp_valid); end
            checks++; if (rsp_rdata !== expR) begin failures++; $display("[TB] FAIL %s rsp_rdata got %h want %h", name, rsp_rdata, expR); end
            checks++; if (rsp_error !== expE) begin failures++; $display("[TB] FAIL %s rsp_error got %b want %b", name, rsp_error, expE); end
            checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL %s cmd_ready_resp got %b want 0", name, cmd_ready); end
            checks++;
            if (data_write_n !== 2'b11 || data_read_n !== 2'b11 || data_read_complete !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s bus_quiet_resp got w=%b r=%b c=%b want 11 11 0", name, data_write_n, data_read_n, data_read_complete);
            end
            rsp_ready = (h == hold);
            step();
        end
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL %s rsp_valid_after got %b want 0", name, rsp_valid); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL %s cmd_ready_after got %b want 1", name, cmd_ready); end
    endtask

    task automatic test_word_write();
        run_txn("word_write", 1'b1, 2'b10, 11'h040, 32'hA5A5_1234, 0, 32'h0, 0);
    endtask

    task automatic test_byte_read();
        run_txn("byte_read", 1'b0, 2'b00, 11'h404, 32'h0, 2, 32'hDEAD_BE5A, 0);
    endtask

    task automatic test_read_timeout();
        run_txn("half_read_timeout", 1'b0, 2'b01, 11'h123, 32'h0, 1000, 32'h1234_5678, 0);
        run_txn("write_timeout", 1'b1, 2'b00, 11'h7FF, 32'hCAFE_F00D, 1000, 32'h0, 1);
        run_txn("read_ready_last", 1'b0, 2'b10, 11'h010, 32'h0, T - 1, 32'h8765_4321, 0);
    endtask

    task automatic test_illegal_size();
        run_txn("illegal_read", 1'b0, 2'b11, 11'h555, 32'h0, 0, 32'hFFFF_FFFF, 0);
        run_txn("illegal_write", 1'b1, 2'b11, 11'h2AA, 32'h1111_2222, 0, 32'h0, 2);
    endtask

    task automatic test_rsp_backpressure();
        run_txn("word_read_hold", 1'b0, 2'b10, 11'h300, 32'h0, 1, 32'h89AB_CDEF, 5);
    endtask

    task automatic test_reset_mid_read();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_read cmd_ready_offer got %b want 1", cmd_ready); end
        cmd_valid  = 1'b1;
        cmd_write  = 1'b0;
        cmd_size   = 2'b01;
        cmd_addr   = 11'h0AB;
        data_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            checks++; if (data_read_n !== 2'b01) begin failures++; $display("[TB] FAIL rst_read read_n_active got %b want 01", data_read_n); end
            if (j < 3) step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (data_read_n !== 2'b11) begin failures++; $display("[TB] FAIL rst_read read_n got %b want 11", data_read_n); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_read cmd_ready got %b want 1", cmd_ready); end
        for (int j = 0; j < 10; j++) begin
            data_ready = 1'($urandom_range(0, 1));
            checks++;
            if (rsp_valid !== 1'b0 || data_read_complete !== 1'b0 || data_read_n !== 2'b11) begin
                failures++;
                $display("[TB] FAIL rst_read after_reset got v=%b c=%b r=%b want 0 0 11", rsp_valid, data_read_complete, data_read_n);
            end
            step();
        end
        data_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_write", 1'b1, 2'b01, 11'h111, 32'h0BAD_BEEF, 0, 32'h0, 0);
        run_txn("b2b_read", 1'b0, 2'b00, 11'h222, 32'h0, 0, 32'h1357_9BDF, 0);
        run_txn("b2b_write2", 1'b1, 2'b10, 11'h333, 32'h2468_ACE0, 3, 32'h0, 0);
    endtask

    task automatic test_random();
        logic       wr;
        logic [1:0] sz;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_txn("random", wr, sz, 11'($urandom), $urandom, int'($urandom_range(0, 10)),
                    $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rsp_ready = 1'b0;
        test_reset();
        test_word_write();
        test_byte_read();
        test_read_timeout();
        test_illegal_size();
        test_rsp_backpressure();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tqv_periph_bus_master.md
# tqv_periph_bus_master

Bus initiator for the TinyQV peripheral interface. It turns single-beat command requests into `data_write_n`/`data_read_n` transactions on the peripheral bus, waits for `data_ready`, pulses `data_read_complete` after a read, and returns read data or an error on a response channel. A debug bridge or DMA sequencer uses it to access peripherals without going through the CPU core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: cycles to wait for `data_ready` before aborting with an error; legal range 2..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when `cmd_valid && cmd_ready`
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- cmd_addr  in  11  peripheral address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when `rsp_valid && rsp_ready`
- rsp_rdata  out  32  read data, zero-extended to size; 0 for writes and errors
- rsp_error  out  1  1 = timeout or illegal size
- addr_out  out  11  bus address
- data_out  out  32  bus write data
- data_write_n  out  2  11 = idle, otherwise the size code
- data_read_n  out  2  11 = idle, otherwise the size code
- data_in  in  32  bus read data
- data_ready  in  1  peripheral ready / read data valid
- data_read_complete  out  1  one-cycle pulse after read data is captured

## Operation
- All bus and response outputs are registered.
- Reset values:
  - cmd_ready = 1
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0
  - addr_out = 0, data_out = 0
  - data_write_n = 11, data_read_n = 11
  - data_read_complete = 0
  - state IDLE
- States:
  - IDLE: cmd_ready = 1. On accept with size 11: go to RESP with error = 1, no bus activity. On accept with a legal write: latch addr/size/wdata, go to WRITE. On accept with a legal read: go to READ. Timeout counter cleared.
  - WRITE: data_write_n = size; addr_out and data_out held.
    - If data_ready is sampled high: data_write_n returns to 11 next cycle; go to RESP with error = 0.
    - Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES-1 with data_ready low: abort, go to RESP with error = 1.
  - READ: data_read_n = size, held until data_ready is sampled high.
    - On data_ready: capture data_in masked to size (byte [7:0], half [15:0]); go to COMPLETE.
    - Timeout is handled as in WRITE: go to RESP with error = 1 and rdata 0. No data_read_complete is pulsed on timeout.
  - COMPLETE (one cycle): data_read_n = 11, data_read_complete = 1. Next state RESP.
  - RESP: rsp_valid = 1, fields stable until rsp_ready. On handshake: rsp_valid = 0 next cycle, back to IDLE.
- cmd_ready is 0 in every state except IDLE. Only one transaction is outstanding at a time.
- data_write_n and data_read_n are never both non-11 in the same cycle.
- rst_n low in any state returns everything to reset values on the next edge. Any in-flight transaction is dropped with no response and no data_read_complete.

## Timing
Command accepted at edge N:
- Bus request is visible from cycle N+1.
- Write, peripheral ready immediately: data_ready is high in the first request cycle, so the write strobe lasts exactly 1 cycle. rsp_valid is high at N+2.
- Read, data_ready first high in cycle M: read_n = 11 and data_read_complete = 1 in cycle M+1, rsp_valid = 1 in cycle M+2. The minimum command-to-response latency is 3 cycles.
- Timeout: the request stays asserted for exactly TIMEOUT_CYCLES cycles; rsp_valid (error) follows in the next cycle.
- Illegal size: rsp_valid is asserted the cycle after accept.
- Back-to-back: after the RESP handshake, cmd_ready is 1 in the following cycle. The next request can therefore start at the earliest 2 cycles after the response handshake.

## Test plan
- Word write addr 0x040, data 0xA5A5_1234, data_ready tied high -> data_write_n = 10 for exactly 1 cycle with addr_out/data_out correct; response error 0, rdata 0.
- Byte read addr 0x404, data_ready high 3 cycles after request, data_in = 0xDEAD_BE5A -> data_read_n = 00 for 3 cycles; data_read_complete pulses once; rsp_rdata = 0x0000_005A.
- Halfword read with data_ready never asserted, TIMEOUT_CYCLES = 8 -> data_read_n = 01 for exactly 8 cycles; rsp_error = 1, rdata 0; data_read_complete never pulses.
- cmd_size = 11 -> no bus activity; rsp_valid with error = 1 one cycle after accept.
- Word read with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable throughout; cmd_ready stays 0 until the cycle after the handshake.
- rst_n pulsed low during READ -> next cycle data_read_n = 11, cmd_ready = 1; no response issued, no data_read_complete pulse.
